sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The block SHALL run on one clock; reset is synchronous and active-high.
REQ-002 Parameter DATA_WIDTH SHALL default to 32 and set the entry width in bits.
REQ-003 Parameter BUFFER_DEPTH SHALL default to 8 and set the number of entries; legal values are powers of two, 2 or more.
REQ-004 Port clk_i SHALL be an input, 1 bit: the clock, sampled on its rising edge.
REQ-005 Port rst_i SHALL be an input, 1 bit: synchronous active-high reset.
REQ-006 Port flush_i SHALL be an input, 1 bit: synchronous clear of all contents.
REQ-007 Port push_i SHALL be an input, 1 bit: write request.
REQ-008 Port dat_i SHALL be an input, DATA_WIDTH bits: write data.
REQ-009 Port pop_i SHALL be an input, 1 bit: read request.
REQ-010 Port dat_o SHALL be an output, DATA_WIDTH bits: head entry.
REQ-011 Port full_o SHALL be an output, 1 bit: no free entry.
REQ-012 Port empty_o SHALL be an output, 1 bit: no valid entry.
REQ-013 Port cnt_o SHALL be an output, $clog2(BUFFER_DEPTH)+1 bits: number of valid entries.
REQ-014 Port ovf_o SHALL be an output, 1 bit: one-cycle pulse marking a rejected push.
REQ-015 Port udf_o SHALL be an output, 1 bit: one-cycle pulse marking a rejected pop.

Function
REQ-016 Storage SHALL be a circular buffer with write pointer, read pointer and occupancy counter, all registered; pointers SHALL be $clog2(BUFFER_DEPTH) bits and wrap from BUFFER_DEPTH-1 to 0.
REQ-017 The block SHALL accept a push when push_i=1 and (full_o=0 or pop_i=1); it writes dat_i at the write pointer and advances the pointer at the clock edge.
REQ-018 The block SHALL accept a pop when pop_i=1 and empty_o=0; it advances the read pointer at the clock edge.
REQ-019 Push and pop accepted together SHALL leave cnt_o unchanged.
REQ-020 Otherwise cnt_o SHALL rise by 1 on an accepted push alone and fall by 1 on an accepted pop alone.
REQ-021 When full, push and pop in the same cycle SHALL both be accepted: the head is removed and new data written, cnt_o stays BUFFER_DEPTH, and ovf_o stays 0.
REQ-022 When empty, push and pop in the same cycle SHALL accept the push only.
  - No fall-through: cnt_o becomes 1.
  - udf_o pulses 1 on the next cycle.
REQ-023 A push with full_o=1 and pop_i=0 SHALL be dropped: contents are unchanged and ovf_o=1 for exactly the next cycle.
REQ-024 A pop with empty_o=1 SHALL be ignored, with udf_o=1 for exactly the next cycle.
REQ-025 full_o SHALL equal (cnt_o==BUFFER_DEPTH) and empty_o SHALL equal (cnt_o==0); both are derived from the registered count.
REQ-026 dat_o SHALL combinationally show the entry at the read pointer when empty_o=0 and SHALL be all-zero when empty_o=0 is false.
  - A pushed word is visible on dat_o in the cycle after its push edge: one-cycle write-to-read latency.
REQ-027 flush_i=1 SHALL zero both pointers and the count at the next edge and SHALL override push_i and pop_i in that cycle.
  - No entry is written.
  - ovf_o and udf_o are 0 in the following cycle.
REQ-028 Storage entries SHALL NOT be reset or cleared by flush_i; only pointers, count and flags are.
REQ-029 Under simulation assertions, an X on push_i, pop_i or flush_i outside reset SHALL be flagged; a BUFFER_DEPTH that is not a power of two or is below 2 SHALL raise an elaboration error.

Reset
REQ-030 With rst_i=1 at a rising edge, the pointers, cnt_o, ovf_o and udf_o SHALL become 0, so that empty_o=1, full_o=0 and dat_o=0.
REQ-031 rst_i SHALL take priority over flush_i, push_i and pop_i.
REQ-032 Reset asserted mid-operation SHALL discard all entries within one cycle.
REQ-033 After rst_i falls, the first push SHALL be accepted at the very next edge.

Verification
REQ-034 Fill and drain (DEPTH=8, WIDTH=32): push 0x10..0x17 -> full_o=1, cnt_o=8; pop ×8 -> dat_o reads 0x10..0x17 in order, then empty_o=1 and dat_o=0.
REQ-035 Overflow: with the FIFO full, push 0xAA with no pop -> ovf_o=1 for one cycle, cnt_o stays 8, and the head stays 0x10.
REQ-036 Simultaneous push and pop when full: push 0xBB with pop -> cnt_o=8, the head advances to 0x11, and 0xBB is read last.
REQ-037 Simultaneous push and pop when empty: push 0xCC with pop -> udf_o=1, cnt_o=1, and dat_o=0xCC on the next cycle.
REQ-038 Wrap-around: run 20 interleaved push/pop cycles at cnt_o of 3 to 5 -> data order is preserved across the pointer wrap.
REQ-039 Flush and reset: with cnt_o=5, raise flush_i together with push_i -> cnt_o=0 and no write. Refill to 3, then raise rst_i with pop_i -> cnt_o=0 and udf_o=0.

Source files
------------

// File: rtl/sync_fifo.sv
// sync_fifo: circular-buffer FIFO with registered occupancy count and
// one-cycle overflow/underflow pulses for rejected pushes and pops.
module sync_fifo #(
    parameter int DATA_WIDTH   = 32,
    parameter int BUFFER_DEPTH = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            flush_i,
    input  logic                            push_i,
    input  logic [DATA_WIDTH-1:0]           dat_i,
    input  logic                            pop_i,
    output logic [DATA_WIDTH-1:0]           dat_o,
    output logic                            full_o,
    output logic                            empty_o,
    output logic [$clog2(BUFFER_DEPTH):0]   cnt_o,
    output logic                            ovf_o,
    output logic                            udf_o
);
    localparam int AW = $clog2(BUFFER_DEPTH);

    if (BUFFER_DEPTH < 2 || (BUFFER_DEPTH & (BUFFER_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo: BUFFER_DEPTH must be a power of two and at least 2");
    end

    logic [DATA_WIDTH-1:0] mem [BUFFER_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic                  do_push, do_pop;

    assign full_o  = cnt_o == (AW + 1)'(BUFFER_DEPTH);
    assign empty_o = cnt_o == '0;
    // a pop frees the slot this cycle, so a full FIFO can still take a push alongside it
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || pop_i);
    assign dat_o   = empty_o ? '0 : mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_o  <= '0;
            ovf_o  <= 1'b0;
            udf_o  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            cnt_o <= cnt_o + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
            ovf_o <= push_i && !do_push;
            udf_o <= pop_i && !do_pop;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i && do_push) mem[wr_ptr] <= dat_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) assert (!$isunknown({push_i, pop_i, flush_i}))
            else $error("sync_fifo: X on push_i/pop_i/flush_i");
    end
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed and random stimulus checked against a queue-based FIFO model.
module tb_sync_fifo;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1, flush_i = 1'b0, push_i = 1'b0, pop_i = 1'b0;
    logic [31:0] dat_i = '0;
    logic [31:0] dat_o;
    logic        full_o, empty_o, ovf_o, udf_o;
    logic [3:0]  cnt_o;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] q[$];
    logic        m_ovf = 1'b0, m_udf = 1'b0;

    sync_fifo dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .push_i(push_i),
        .dat_i(dat_i), .pop_i(pop_i), .dat_o(dat_o), .full_o(full_o),
        .empty_o(empty_o), .cnt_o(cnt_o), .ovf_o(ovf_o), .udf_o(udf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".cnt"}, 64'(cnt_o), 64'(q.size()));
        chk({tag, ".empty"}, 64'(empty_o), 64'(q.size() == 0));
        chk({tag, ".full"}, 64'(full_o), 64'(q.size() == 8));
        chk({tag, ".dat"}, 64'(dat_o), q.size() != 0 ? 64'(q[0]) : 64'h0);
        chk({tag, ".ovf"}, 64'(ovf_o), 64'(m_ovf));
        chk({tag, ".udf"}, 64'(udf_o), 64'(m_udf));
    endtask

    // drive one cycle, advance the model across the edge, then compare
    task automatic step(input string tag, input logic r, input logic f,
                        input logic pu, input logic po, input logic [31:0] d);
        bit acc_push, acc_pop;
        rst_i = r; flush_i = f; push_i = pu; pop_i = po; dat_i = d;
        @(posedge clk_i);
        if (r || f) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            acc_pop  = po && q.size() > 0;
            acc_push = pu && (q.size() < 8 || po);
            if (acc_pop) void'(q.pop_front());
            if (acc_push) q.push_back(d);
            m_ovf = pu && !acc_push;
            m_udf = po && !acc_pop;
        end
        #1;
        chk_model(tag);
    endtask

    initial begin
        logic pu, po;
        int   sz;
        step("reset", 1, 0, 0, 0, 0);
        step("reset", 1, 0, 1, 1, 32'h55);
        chk("reset_dat", 64'(dat_o), 64'h0);
        chk("reset_empty", 64'(empty_o), 64'h1);

        for (int i = 0; i < 8; i++) step("fill", 0, 0, 1, 0, 32'h10 + 32'(i));
        chk("fill_full", 64'(full_o), 64'h1);
        chk("fill_cnt", 64'(cnt_o), 64'h8);
        for (int i = 0; i < 8; i++) begin
            chk("drain_order", 64'(dat_o), 64'h10 + 64'(i));
            step("drain", 0, 0, 0, 1, 0);
        end
        chk("drain_empty", 64'(empty_o), 64'h1);
        chk("drain_dat0", 64'(dat_o), 64'h0);

        for (int i = 0; i < 8; i++) step("refill", 0, 0, 1, 0, 32'h10 + 32'(i));
        step("ovf", 0, 0, 1, 0, 32'hAA);
        chk("ovf_pulse", 64'(ovf_o), 64'h1);
        chk("ovf_head", 64'(dat_o), 64'h10);
        step("ovf_clear", 0, 0, 0, 0, 0);
        chk("ovf_one_cycle", 64'(ovf_o), 64'h0);
        step("full_pushpop", 0, 0, 1, 1, 32'hBB);
        chk("full_pp_cnt", 64'(cnt_o), 64'h8);
        chk("full_pp_head", 64'(dat_o), 64'h11);
        chk("full_pp_ovf", 64'(ovf_o), 64'h0);
        for (int i = 0; i < 7; i++) step("drain2", 0, 0, 0, 1, 0);
        chk("bb_last", 64'(dat_o), 64'hBB);
        step("drain2", 0, 0, 0, 1, 0);
        step("udf", 0, 0, 0, 1, 0);
        chk("udf_pulse", 64'(udf_o), 64'h1);

        step("empty_pushpop", 0, 0, 1, 1, 32'hCC);
        chk("empty_pp_udf", 64'(udf_o), 64'h1);
        chk("empty_pp_cnt", 64'(cnt_o), 64'h1);
        chk("empty_pp_dat", 64'(dat_o), 64'hCC);
        step("pop_cc", 0, 0, 0, 1, 0);

        for (int i = 0; i < 4; i++) step("wrap_pre", 0, 0, 1, 0, $urandom);
        for (int i = 0; i < 20; i++) begin
            sz = q.size();
            pu = (sz == 3) ? 1'b1 : (sz == 5) ? 1'b0 : 1'($urandom);
            po = (sz == 5) ? 1'b1 : (sz == 3) ? 1'($urandom) : 1'($urandom);
            step("wrap", 0, 0, pu, po, $urandom);
        end
        while (q.size() < 5) step("to5", 0, 0, 1, 0, $urandom);
        while (q.size() > 5) step("to5", 0, 0, 0, 1, 0);
        step("flush", 0, 1, 1, 0, 32'hDEAD);
        chk("flush_cnt", 64'(cnt_o), 64'h0);
        chk("flush_ovf", 64'(ovf_o), 64'h0);
        for (int i = 0; i < 3; i++) step("refill3", 0, 0, 1, 0, 32'h30 + 32'(i));
        chk("refill3_head", 64'(dat_o), 64'h30);
        step("rst_pop", 1, 0, 0, 1, 0);
        chk("rst_pop_cnt", 64'(cnt_o), 64'h0);
        chk("rst_pop_udf", 64'(udf_o), 64'h0);
        step("post_rst_push", 0, 0, 1, 0, 32'h77);
        chk("post_rst_cnt", 64'(cnt_o), 64'h1);

        for (int i = 0; i < 400; i++)
            step("random", 0, ($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom), $urandom);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
